// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner: advances one digit per scan_clk
// edge, with a one-cycle all-off gap before every digit change.
module seg_scan #(
  parameter bit ADV_BOTH_EDGES = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        scan_clk,
  input  logic [31:0] data,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_idx
);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic        pending;
  logic        pending_nxt;
  logic [31:0] snap_data;
  logic [31:0] snap_data_nxt;
  logic [7:0]  snap_blank;
  logic [7:0]  snap_blank_nxt;
  logic [7:0]  snap_dp;
  logic [7:0]  snap_dp_nxt;

  logic        s1;
  logic        s2;
  logic        s3;
  logic [1:0]  warm;
  logic        edge_seen;
  logic        tick;
  logic        adv;

  logic [7:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;
  logic [3:0]  nibble;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0:    r = 7'h3F;
      4'h1:    r = 7'h06;
      4'h2:    r = 7'h5B;
      4'h3:    r = 7'h4F;
      4'h4:    r = 7'h66;
      4'h5:    r = 7'h6D;
      4'h6:    r = 7'h7D;
      4'h7:    r = 7'h07;
      4'h8:    r = 7'h7F;
      4'h9:    r = 7'h6F;
      4'hA:    r = 7'h77;
      4'hB:    r = 7'h7C;
      4'hC:    r = 7'h39;
      4'hD:    r = 7'h5E;
      4'hE:    r = 7'h79;
      default: r = 7'h71;
    endcase
    return r;
  endfunction

  // scan_clk is asynchronous data: two-flop synchronizer plus a history flop.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 only holds a genuine sample three cycles after reset; until then a
  // high scan_clk level would look like a rising edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      warm <= 2'd0;
    end else if (warm != 2'd3) begin
      warm <= warm + 2'd1;
    end
  end

  always_comb begin
    if (ADV_BOTH_EDGES) begin
      edge_seen = s2 ^ s3;
    end else begin
      edge_seen = s2 & ~s3;
    end
    tick = edge_seen & (warm == 2'd3);
    adv  = tick | pending;
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      idx        <= 3'd0;
      pending    <= 1'b0;
      snap_data  <= 32'h0;
      snap_blank <= 8'h0;
      snap_dp    <= 8'h0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pending    <= pending_nxt;
      snap_data  <= snap_data_nxt;
      snap_blank <= snap_blank_nxt;
      snap_dp    <= snap_dp_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    pending_nxt    = pending;
    snap_data_nxt  = snap_data;
    snap_blank_nxt = snap_blank;
    snap_dp_nxt    = snap_dp;
    case (state)
      BLANK: begin
        state_nxt   = DRIVE;
        pending_nxt = pending | tick;
        if (idx == 3'd0) begin
          snap_data_nxt  = data;
          snap_blank_nxt = blank_mask;
          snap_dp_nxt    = dp_mask;
        end
      end
      default: begin
        if (adv) begin
          idx_nxt   = idx + 3'd1;
          state_nxt = BLANK;
          // A fresh tick coinciding with a consumed pending one stays queued.
          pending_nxt = pending & tick;
        end
      end
    endcase
  end

  // Output logic: computed from next state so the registered outputs match
  // the state and idx of the cycle they are shown in.
  always_comb begin
    nibble = snap_data_nxt[{idx_nxt, 2'b00} +: 4];
    an_d   = 8'hFF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (state_nxt == DRIVE && !snap_blank_nxt[idx_nxt]) begin
      an_d  = ~(8'b1 << idx_nxt);
      seg_d = ~hex_decode(nibble);
      dp_d  = ~snap_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      an        <= 8'hFF;
      seg       <= 7'h7F;
      dp        <= 1'b1;
      digit_idx <= 3'd0;
    end else begin
      an        <= an_d;
      seg       <= seg_d;
      dp        <= dp_d;
      digit_idx <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: one instance advancing on rising edges only,
// one advancing on both edges, sharing clock, reset, data and masks.
module tb_seg_scan;

  logic        clk;
  logic        rst_n;
  logic        scan_a;
  logic        scan_b;
  logic [31:0] data;
  logic [7:0]  blank_mask;
  logic [7:0]  dp_mask;

  logic [7:0]  an_a;
  logic [6:0]  seg_a;
  logic        dp_a;
  logic [2:0]  digit_idx_a;
  logic [7:0]  an_b;
  logic [6:0]  seg_b;
  logic        dp_b;
  logic [2:0]  digit_idx_b;

  int checks;
  int errors;

  logic [6:0] seg_tab [0:7];
  logic [7:0] an_tab  [0:7];

  seg_scan #(.ADV_BOTH_EDGES(1'b0)) dut_a (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .scan_clk   (scan_a),
    .data       (data),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .an         (an_a),
    .seg        (seg_a),
    .dp         (dp_a),
    .digit_idx  (digit_idx_a)
  );

  seg_scan #(.ADV_BOTH_EDGES(1'b1)) dut_b (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .scan_clk   (scan_b),
    .data       (data),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .an         (an_b),
    .seg        (seg_b),
    .dp         (dp_b),
    .digit_idx  (digit_idx_b)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] ea, input logic [6:0] es,
                       input logic ed, input logic [2:0] ei);
    checks++;
    assert (an_a === ea) else begin
      errors++;
      $error("FAIL %s an obs=%h exp=%h", tag, an_a, ea);
    end
    checks++;
    assert (seg_a === es) else begin
      errors++;
      $error("FAIL %s seg obs=%h exp=%h", tag, seg_a, es);
    end
    checks++;
    assert (dp_a === ed) else begin
      errors++;
      $error("FAIL %s dp obs=%b exp=%b", tag, dp_a, ed);
    end
    checks++;
    assert (digit_idx_a === ei) else begin
      errors++;
      $error("FAIL %s digit_idx obs=%0d exp=%0d", tag, digit_idx_a, ei);
    end
  endtask

  task automatic chk_b(input string tag, input logic [7:0] ea, input logic [6:0] es,
                       input logic ed, input logic [2:0] ei);
    checks++;
    assert (an_b === ea) else begin
      errors++;
      $error("FAIL %s an obs=%h exp=%h", tag, an_b, ea);
    end
    checks++;
    assert (seg_b === es) else begin
      errors++;
      $error("FAIL %s seg obs=%h exp=%h", tag, seg_b, es);
    end
    checks++;
    assert (dp_b === ed) else begin
      errors++;
      $error("FAIL %s dp obs=%b exp=%b", tag, dp_b, ed);
    end
    checks++;
    assert (digit_idx_b === ei) else begin
      errors++;
      $error("FAIL %s digit_idx obs=%0d exp=%0d", tag, digit_idx_b, ei);
    end
  endtask

  // Driver: one rising scan_clk edge on dut_a, checking the blank gap, the
  // new digit, and that the following falling edge does not advance.
  task automatic rise_a(input string tag, input logic [7:0] ea, input logic [6:0] es,
                        input logic ed, input logic [2:0] ei);
    scan_a = 1'b1;
    step(3);
    chk_a({tag, "_gap"}, 8'hFF, 7'h7F, 1'b1, ei);
    step(1);
    chk_a(tag, ea, es, ed, ei);
    scan_a = 1'b0;
    step(5);
    chk_a({tag, "_hold"}, ea, es, ed, ei);
  endtask

  // Driver: one scan_clk toggle on dut_b, spaced exactly four cycles.
  task automatic tog_b(input string tag, input logic [7:0] ea, input logic [6:0] es,
                       input logic ed, input logic [2:0] ei);
    scan_b = ~scan_b;
    step(3);
    chk_b({tag, "_gap"}, 8'hFF, 7'h7F, 1'b1, ei);
    step(1);
    chk_b(tag, ea, es, ed, ei);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Active-low segments for nibbles 0..7 and active-low anodes for digits 0..7.
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    an_tab[0] = 8'hFE; an_tab[1] = 8'hFD; an_tab[2] = 8'hFB; an_tab[3] = 8'hF7;
    an_tab[4] = 8'hEF; an_tab[5] = 8'hDF; an_tab[6] = 8'hBF; an_tab[7] = 8'h7F;

    rst_n      = 1'b0;
    scan_a     = 1'b0;
    scan_b     = 1'b0;
    data       = 32'h76543210;
    blank_mask = 8'h00;
    dp_mask    = 8'h00;
    step(3);
    chk_a("a_reset", 8'hFF, 7'h7F, 1'b1, 3'd0);
    chk_b("b_reset", 8'hFF, 7'h7F, 1'b1, 3'd0);

    // Release: one BLANK cycle, then digit 0.
    rst_n = 1'b1;
    #1;
    chk_a("a_rel_blank", 8'hFF, 7'h7F, 1'b1, 3'd0);
    step(1);
    chk_a("a_d0", 8'hFE, 7'h40, 1'b1, 3'd0);
    chk_b("b_d0", 8'hFE, 7'h40, 1'b1, 3'd0);
    step(2);

    // Both-edge instance: toggle every four cycles through a full frame.
    for (int i = 1; i <= 8; i++) begin
      tog_b("b_scan", an_tab[i % 8], seg_tab[i % 8], 1'b1, 3'(i % 8));
    end
    // Two toggles one cycle apart: the second lands in BLANK and is held.
    scan_b = ~scan_b;
    step(1);
    scan_b = ~scan_b;
    step(2);
    chk_b("b_pend_gap1", 8'hFF, 7'h7F, 1'b1, 3'd1);
    step(1);
    chk_b("b_pend_d1", 8'hFD, 7'h79, 1'b1, 3'd1);
    step(1);
    chk_b("b_pend_gap2", 8'hFF, 7'h7F, 1'b1, 3'd2);
    step(1);
    chk_b("b_pend_d2", 8'hFB, 7'h24, 1'b1, 3'd2);
    step(8);
    chk_b("b_pend_hold", 8'hFB, 7'h24, 1'b1, 3'd2);
    chk_a("a_idle", 8'hFE, 7'h40, 1'b1, 3'd0);

    // Rising-edge instance: digits 1..3, then change data mid-frame.
    for (int i = 1; i <= 3; i++) begin
      rise_a("a_scan", an_tab[i], seg_tab[i], 1'b1, 3'(i));
    end
    data = 32'hFFFFFFFF;
    step(1);
    chk_a("a_mid_d3", 8'hF7, 7'h30, 1'b1, 3'd3);
    for (int i = 4; i <= 7; i++) begin
      rise_a("a_old", an_tab[i], seg_tab[i], 1'b1, 3'(i));
    end
    rise_a("a_wrap_f0", 8'hFE, 7'h0E, 1'b1, 3'd0);
    rise_a("a_f1", 8'hFD, 7'h0E, 1'b1, 3'd1);

    // Masks change mid-frame; the rest of this frame is unaffected.
    blank_mask = 8'h0F;
    dp_mask    = 8'h80;
    for (int i = 2; i <= 7; i++) begin
      rise_a("a_mask_old", an_tab[i], 7'h0E, 1'b1, 3'(i));
    end
    for (int i = 0; i <= 3; i++) begin
      rise_a("a_blanked", 8'hFF, 7'h7F, 1'b1, 3'(i));
    end
    for (int i = 4; i <= 6; i++) begin
      rise_a("a_lit", an_tab[i], 7'h0E, 1'b1, 3'(i));
    end
    rise_a("a_dp7", 8'h7F, 7'h0E, 1'b0, 3'd7);

    // Advance to digit 5, then pulse reset with scan_clk already high.
    for (int i = 0; i <= 3; i++) begin
      rise_a("a_to5_blk", 8'hFF, 7'h7F, 1'b1, 3'(i));
    end
    rise_a("a_to5_d4", 8'hEF, 7'h0E, 1'b1, 3'd4);
    rise_a("a_to5_d5", 8'hDF, 7'h0E, 1'b1, 3'd5);
    rst_n = 1'b0;
    #1;
    chk_a("a_async_rst", 8'hFF, 7'h7F, 1'b1, 3'd0);
    data       = 32'h76543210;
    blank_mask = 8'h00;
    dp_mask    = 8'h00;
    scan_a     = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk_a("a_rst2_blank", 8'hFF, 7'h7F, 1'b1, 3'd0);
    step(1);
    chk_a("a_rst2_d0", 8'hFE, 7'h40, 1'b1, 3'd0);
    step(10);
    chk_a("a_level_no_tick", 8'hFE, 7'h40, 1'b1, 3'd0);
    scan_a = 1'b0;
    step(4);
    rise_a("a_rst2_d1", 8'hFD, 7'h79, 1'b1, 3'd1);

    // Final report.
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
